red_pitaya_sys_arb: RTL
=======================

# red_pitaya_sys_arb

Round-robin arbiter that shares the single PS-side system bus master (the GP-port sys-bus exposed by the `system` block design) between NR fabric requesters. Each requester issues one read or write at a time. The arbiter serialises the transactions onto the sys-bus, returns the response to the winner, and converts a missing slave acknowledge into an error after a timeout. It sits between the PS system block and the fabric register clients.

## Interface
Parameters:
- NR, 4: number of requesters, 2..8
- AW, 32: address width
- DW, 32: data width
- TMO, 255: cycles to wait for sys_ack/sys_err before forcing an error, 1..65535

Ports:
- clk_i  in  1  system clock; all logic is on this single clock
- rst_i  in  1  reset, asynchronous, active-high
- req_vld_i  in  NR  request pending, one bit per requester; held until acknowledged
- req_we_i  in  NR  1 = write, 0 = read
- req_addr_i  in  NR×AW  request address
- req_wdata_i  in  NR×DW  write data
- req_sel_i  in  NR×DW/8  byte enables
- req_ack_o  out  NR  one-cycle completion pulse to the winner
- req_err_o  out  1  error flag, valid with req_ack_o
- req_rdata_o  out  DW  read data, valid with req_ack_o; 0 on error or write
- sys_addr_o  out  AW  bus address
- sys_wdata_o  out  DW  bus write data
- sys_sel_o  out  DW/8  bus byte enables
- sys_wen_o  out  1  one-cycle write strobe
- sys_ren_o  out  1  one-cycle read strobe
- sys_rdata_i  in  DW  bus read data
- sys_ack_i  in  1  slave acknowledge
- sys_err_i  in  1  slave error

## Operation
- FSM states and transitions:
  - IDLE: if any req_vld_i is set, select the winner and go to ISSUE.
  - ISSUE: drive one strobe; on completion go to IDLE, otherwise go to WAIT.
  - WAIT: on completion or timeout go to IDLE.
- Winner selection:
  - Round-robin. Search starts at the index after last_gnt and wraps modulo NR.
  - last_gnt resets to NR-1, so requester 0 has first priority.
  - last_gnt updates only when a transaction completes.
- Registering: on IDLE→ISSUE the winner's we/addr/wdata/sel are captured into holding registers. sys_addr_o, sys_wdata_o and sys_sel_o are driven from these registers and stay stable until the next grant.
- Strobes:
  - ISSUE asserts sys_wen_o (if we=1) or sys_ren_o (if we=0) for exactly one cycle.
  - A strobe is never asserted in WAIT or IDLE.
- Completion:
  - sys_ack_i or sys_err_i sampled high in ISSUE or WAIT completes the transaction.
  - On completion, req_ack_o[gnt], req_err_o = sys_err_i and req_rdata_o = (read and not err) ? sys_rdata_i : 0 are registered.
  - If ack and err are both high, it is an error.
- Timeout:
  - The counter clears on grant and increments in ISSUE and WAIT.
  - When it reaches TMO with no ack or err, the transaction completes with req_err_o=1 and req_rdata_o=0.
- Late acknowledges: an ack or err arriving in IDLE is ignored. A slave acking after TMO is a slave protocol violation and is not tracked.
- Requester rule: req_vld_i deasserts in the cycle after req_ack_o, or re-asserts for a new request. Request fields are don't-care while vld=0.
- A requester that drops vld before its grant is simply not selected. Once granted, dropping vld has no effect: the transaction runs to completion.
- Reset asserted mid-transaction: all state returns to reset immediately, with no strobe or ack issued. The outstanding slave response is ignored because the FSM is in IDLE.

## Timing
- Reset values:
  - FSM = IDLE, last_gnt = NR-1, counter = 0.
  - req_ack_o = 0, req_err_o = 0, req_rdata_o = 0.
  - sys_wen_o = 0, sys_ren_o = 0, sys_addr_o = 0, sys_wdata_o = 0, sys_sel_o = 0.
- Latency: vld seen at edge t (IDLE) → strobe in cycle t+1 → slave ack in cycle t+1+k (k≥0) → req_ack_o in cycle t+2+k.
- Minimum turnaround with a same-cycle ack: 3 cycles per transaction, i.e. the next strobe comes 3 cycles after the previous one.
- Timeout: req_ack_o with err=1 occurs TMO+1 cycles after the strobe.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package red_pitaya_sys_arb_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT);
  - the timeout counter width function clog2(TMO+1).
- Sub-module rr_pick: combinational round-robin selector. Inputs are the NR-bit request vector and last_gnt. Outputs are a valid flag and the winner index. It is reusable by other arbiters in the design.

## Test plan
- Single read: req 0 reads 0x40000010, slave acks 1 cycle after strobe with 0xDEADBEEF → one sys_ren_o pulse, req_ack_o=0b0001 with rdata 0xDEADBEEF, err=0.
- Fairness: all four vld held with back-to-back requests, slave acks same cycle → grant order 0,1,2,3,0,1… and no requester is granted twice before the others.
- Write with byte enables: req 2 writes 0x12345678 with sel=0b0011 to 0x40100000 → sys_wen_o for one cycle with matching addr/wdata/sel, req_ack_o[2] asserted, rdata=0.
- Timeout: TMO=8 and the slave never responds → req_ack_o with err=1 and rdata=0 exactly 9 cycles after the strobe, then the next request is served normally.
- Slave error: sys_err_i with sys_ack_i and rdata=0xFFFFFFFF → err=1, rdata=0.
- Reset mid-WAIT: rst_i asserted while waiting → all outputs return to reset values, and a late ack after reset produces no req_ack_o.

Source files
------------

// File: rtl/red_pitaya_sys_arb_pkg.sv
// Shared types and helpers for the sys-bus round-robin arbiter.
package red_pitaya_sys_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  // Counter width that can hold the value tmo.
  function automatic int cnt_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/red_pitaya_sys_arb_rr_pick.sv
// Combinational round-robin selector: first pending request after last_gnt, wrapping.
module rr_pick #(
  parameter int NR = 4,
  parameter int IW = $clog2(NR)
) (
  input  logic [NR-1:0] req,
  input  logic [IW-1:0] last_gnt,
  output logic          vld,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] offset_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NR;
    return IW'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    vld = 1'b0;
    idx = '0;
    for (int i = 1; i <= NR; i++) begin
      if (!vld && req[offset_idx(last_gnt, i)]) begin
        vld = 1'b1;
        idx = offset_idx(last_gnt, i);
      end
    end
  end

endmodule

// File: rtl/red_pitaya_sys_arb.sv
// Serialises NR fabric requesters onto the single PS sys-bus, with round-robin
// grant and a timeout that turns a missing slave response into an error.
module red_pitaya_sys_arb
  import red_pitaya_sys_arb_pkg::*;
#(
  parameter int NR  = 4,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NR-1:0]          req_vld_i,
  input  logic [NR-1:0]          req_we_i,
  input  logic [NR*AW-1:0]       req_addr_i,
  input  logic [NR*DW-1:0]       req_wdata_i,
  input  logic [NR*(DW/8)-1:0]   req_sel_i,
  output logic [NR-1:0]          req_ack_o,
  output logic                   req_err_o,
  output logic [DW-1:0]          req_rdata_o,
  output logic [AW-1:0]          sys_addr_o,
  output logic [DW-1:0]          sys_wdata_o,
  output logic [DW/8-1:0]        sys_sel_o,
  output logic                   sys_wen_o,
  output logic                   sys_ren_o,
  input  logic [DW-1:0]          sys_rdata_i,
  input  logic                   sys_ack_i,
  input  logic                   sys_err_i
);

  localparam int IW = $clog2(NR);
  localparam int CW = cnt_width(TMO);
  localparam int SW = DW / 8;

  state_t        state, state_nxt;
  logic [IW-1:0] last_gnt, gnt, pick_idx;
  logic          pick_vld;
  logic          hold_we;
  logic [CW-1:0] cnt;
  logic          grant, done, tmo_hit;

  rr_pick #(.NR(NR), .IW(IW)) u_rr_pick (
    .req      (req_vld_i),
    .last_gnt (last_gnt),
    .vld      (pick_vld),
    .idx      (pick_idx)
  );

  // The cycle that carries req_ack_o is skipped for granting: the acked
  // requester's vld is still high then and would otherwise be re-granted.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && !(|req_ack_o)) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (sys_ack_i || sys_err_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CW'(TMO)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_gnt    <= IW'(NR - 1);
      gnt         <= '0;
      hold_we     <= 1'b0;
      cnt         <= '0;
      req_ack_o   <= '0;
      req_err_o   <= 1'b0;
      req_rdata_o <= '0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_sel_o   <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
      req_ack_o   <= '0;
      req_err_o   <= 1'b0;
      req_rdata_o <= '0;

      if (grant) begin
        gnt         <= pick_idx;
        hold_we     <= req_we_i[pick_idx];
        sys_addr_o  <= req_addr_i[pick_idx*AW +: AW];
        sys_wdata_o <= req_wdata_i[pick_idx*DW +: DW];
        sys_sel_o   <= req_sel_i[pick_idx*SW +: SW];
        sys_wen_o   <= req_we_i[pick_idx];
        sys_ren_o   <= !req_we_i[pick_idx];
        cnt         <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end

      if (done || tmo_hit) begin
        req_ack_o[gnt] <= 1'b1;
        last_gnt       <= gnt;
        req_err_o      <= tmo_hit | sys_err_i;
        req_rdata_o    <= (done && !hold_we && !sys_err_i) ? sys_rdata_i : '0;
      end
    end
  end

endmodule
